// File: rtl/edge_scan_scheduler.sv
// rtl/edge_scan_scheduler.sv - round-robin tick-paced dual-edge scanner with valid/ready event port
// Optional macro EDGE_SCAN_SYNC_EN: adds a two-flop synchronizer on every i_lvl bit.
module edge_scan_scheduler #(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_CH-1:0]         i_lvl,
    output logic                    o_slot_tick,
    output logic [$clog2(N_CH)-1:0] o_sel,
    output logic                    o_edge_vld,
    input  logic                    i_edge_rdy,
    output logic [$clog2(N_CH)-1:0] o_edge_ch,
    output logic                    o_edge_rise,
    output logic [N_CH-1:0]         o_lvl_q,
    output logic                    o_overrun
);

    localparam int SW = $clog2(N_CH);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [SW-1:0] SEL_LAST = SW'(N_CH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    logic [CW-1:0]   cnt_q;
    logic            tick;
    logic [N_CH-1:0] s;

    logic [1:0]      state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   sel_inc;
    logic [N_CH-1:0] lvl_q, lvl_d;
    logic [SW-1:0]   edge_ch_q, edge_ch_d;
    logic            edge_rise_q, edge_rise_d;
    logic            overrun_q, overrun_d;

`ifdef EDGE_SCAN_SYNC_EN
    logic [N_CH-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous switch/button inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_lvl;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = i_lvl;
`endif

    // Free-running slot prescaler; wraps at TICK_DIV-1 regardless of FSM state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick    = (cnt_q == CNT_LAST);
    assign sel_inc = (sel_q == SEL_LAST) ? '0 : sel_q + SW'(1);

    // Scan FSM: INIT captures every channel once, WAIT compares, REPORT holds the event.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        lvl_d       = lvl_q;
        edge_ch_d   = edge_ch_q;
        edge_rise_d = edge_rise_q;
        overrun_d   = overrun_q;
        case (state_q)
            ST_INIT: begin
                if (tick) begin
                    lvl_d[sel_q] = s[sel_q];
                    sel_d        = sel_inc;
                    if (sel_q == SEL_LAST) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    if (s[sel_q] != lvl_q[sel_q]) begin
                        lvl_d[sel_q] = s[sel_q];
                        edge_ch_d    = sel_q;
                        edge_rise_d  = s[sel_q];
                        state_d      = ST_REPORT;
                    end else begin
                        sel_d = sel_inc;
                    end
                end
            end
            ST_REPORT: begin
                // A tick here cannot be serviced; flag it even if the handshake completes now.
                if (tick) begin
                    overrun_d = 1'b1;
                end
                if (i_edge_rdy) begin
                    sel_d   = sel_inc;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_INIT;
                sel_d   = '0;
            end
        endcase
    end

    // State and payload registers; reset discards any pending event and restarts INIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_INIT;
            sel_q       <= '0;
            lvl_q       <= '0;
            edge_ch_q   <= '0;
            edge_rise_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            lvl_q       <= lvl_d;
            edge_ch_q   <= edge_ch_d;
            edge_rise_q <= edge_rise_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_slot_tick = tick;
    assign o_sel       = sel_q;
    assign o_edge_vld  = (state_q == ST_REPORT);
    assign o_edge_ch   = edge_ch_q;
    assign o_edge_rise = edge_rise_q;
    assign o_lvl_q     = lvl_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_edge_scan_scheduler.sv
// tb/tb_edge_scan_scheduler.sv - directed self-checking bench for edge_scan_scheduler
module tb_edge_scan_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] lvl;
    logic       rdy;
    logic       slot_tick;
    logic [1:0] sel;
    logic       vld;
    logic [1:0] ech;
    logic       erise;
    logic [3:0] lvl_q;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vld_cnt  = 0;
    logic [2:0] ev_q[$];
    logic [2:0] exp_ev [5];

    edge_scan_scheduler #(.N_CH(4), .TICK_DIV(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_lvl      (lvl),
        .o_slot_tick(slot_tick),
        .o_sel      (sel),
        .o_edge_vld (vld),
        .i_edge_rdy (rdy),
        .o_edge_ch  (ech),
        .o_edge_rise(erise),
        .o_lvl_q    (lvl_q),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Event sink model: records valid cycles and completed handshakes.
    always @(posedge clk) begin
        if (rst_n) begin
            if (vld) vld_cnt <= vld_cnt + 1;
            if (vld && rdy) ev_q.push_back({ech, erise});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    task automatic to(input int c);
        adv(c - cyc);
    endtask

    initial begin
        logic [2:0] obs_ev;
        exp_ev = '{3'b101, 3'b100, 3'b010, 3'b110, 3'b001};
        rst_n = 1'b0;
        lvl   = 4'b1010;
        rdy   = 1'b1;
        adv(3);
        chk("rst_tick", slot_tick, 0);
        chk("rst_sel", sel, 0);
        chk("rst_vld", vld, 0);
        chk("rst_ch", ech, 0);
        chk("rst_rise", erise, 0);
        chk("rst_lvlq", lvl_q, 0);
        chk("rst_ovr", overrun, 0);

        rst_n = 1'b1;
        cyc   = 0;
        to(2);  chk("init_tick_c2", slot_tick, 0);
        to(3);  chk("init_tick_c3", slot_tick, 1);
        to(4);  chk("init_sel_c4", sel, 1);
        to(8);  chk("init_lvlq_c8", lvl_q, 4'b0010);
                chk("init_sel_c8", sel, 2);
        to(16); chk("init_lvlq", lvl_q, 4'b1010);
                chk("init_sel", sel, 0);
                chk("init_vld", vld, 0);
                chk("init_vld_cnt", vld_cnt, 0);
                chk("init_ovr", overrun, 0);

        lvl = 4'b1110;
        to(28); chk("rise_vld", vld, 1);
                chk("rise_ch", ech, 2);
                chk("rise_dir", erise, 1);
                chk("rise_sel", sel, 2);
                chk("rise_lvlq", lvl_q, 4'b1110);
        to(29); chk("rise_vld_drop", vld, 0);
                chk("rise_sel_adv", sel, 3);

        lvl = 4'b1010;
        to(44); chk("fall_vld", vld, 1);
                chk("fall_ch", ech, 2);
                chk("fall_dir", erise, 0);
        to(45); chk("fall_vld_drop", vld, 0);
                chk("fall_sel_adv", sel, 3);

        lvl = 4'b1000;
        rdy = 1'b0;
        to(56);
        for (int c = 56; c < 68; c++) begin
            to(c);
            chk("bp_vld", vld, 1);
            chk("bp_ch", ech, 1);
            chk("bp_dir", erise, 0);
            chk("bp_sel", sel, 1);
            chk("bp_ovr", overrun, (c >= 60) ? 1 : 0);
        end
        to(68); rdy = 1'b1;
                chk("bp_vld_c68", vld, 1);
        to(69); chk("bp_vld_drop", vld, 0);
                chk("bp_sel_resume", sel, 2);
                chk("bp_ovr_sticky", overrun, 1);

        to(80); chk("sim_sel", sel, 1);
                lvl = 4'b0001;
        to(92); chk("sim1_vld", vld, 1);
                chk("sim1_ch", ech, 3);
                chk("sim1_dir", erise, 0);
        to(94); chk("sim_gap_vld", vld, 0);
        to(96); chk("sim2_vld", vld, 1);
                chk("sim2_ch", ech, 0);
                chk("sim2_dir", erise, 1);
        to(97); chk("sim_lvlq", lvl_q, 4'b0001);
                chk("sim_sel_end", sel, 1);

        to(100); lvl = 4'b0011;
        to(103); lvl = 4'b0001;
        to(116); chk("glitch_lvlq", lvl_q, 4'b0001);
                 chk("glitch_sel", sel, 2);
                 chk("glitch_events", ev_q.size(), 5);

        lvl = 4'b0101;
        rdy = 1'b0;
        to(120); chk("rr_vld", vld, 1);
                 chk("rr_ch", ech, 2);
        to(121); rst_n = 1'b0;
        #1;
        chk("rr_vld0", vld, 0);
        chk("rr_sel0", sel, 0);
        chk("rr_ch0", ech, 0);
        chk("rr_rise0", erise, 0);
        chk("rr_lvlq0", lvl_q, 0);
        chk("rr_ovr0", overrun, 0);
        chk("rr_tick0", slot_tick, 0);
        adv(2);
        rdy   = 1'b1;
        rst_n = 1'b1;
        cyc   = 0;
        to(3);  chk("rr_init_tick", slot_tick, 1);
        to(16); chk("rr_init_lvlq", lvl_q, 4'b0101);
                chk("rr_init_sel", sel, 0);
                chk("rr_init_vld", vld, 0);
                chk("total_vld_cycles", vld_cnt, 18);
                chk("total_events", ev_q.size(), 5);

        for (int i = 0; i < 5; i++) begin
            obs_ev = (i < ev_q.size()) ? ev_q[i] : 3'b111;
            chk($sformatf("event_%0d", i), obs_ev, exp_ev[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_scan_scheduler.md
# edge_scan_scheduler

Round-robin scheduler that shares a single tick-paced dual-edge detection slot among `N_CH` level inputs (switches/buttons).
- A prescaler generates a slow slot tick; each tick inspects one channel and compares it with that channel's last accepted level.
- Detected edges are reported through a valid/ready event port, so the event sink (LED/pin driver, counter, UART logger) never misses an edge.
- Sits between the board switch inputs and the event consumers.

## Interface
- `N_CH`, 4: number of scanned channels, ≥2.
- `TICK_DIV`, 16: clock cycles per scan slot, ≥2.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_lvl`  in  N_CH  raw channel levels.
- `o_slot_tick`  out  1  one-cycle pulse marking each scan slot.
- `o_sel`  out  $clog2(N_CH)  channel currently scheduled.
- `o_edge_vld`  out  1  edge event valid.
- `i_edge_rdy`  in  1  sink accepts the event.
- `o_edge_ch`  out  $clog2(N_CH)  channel of the event.
- `o_edge_rise`  out  1  1 = rising edge, 0 = falling edge.
- `o_lvl_q`  out  N_CH  last accepted level per channel.
- `o_overrun`  out  1  sticky: a slot tick was lost while an event was pending.

## Operation
- **Prescaler:** counter runs 0..TICK_DIV-1 and wraps. `o_slot_tick` = 1 when count == TICK_DIV-1. It free-runs in all states.
- **Sampled level `s`:** `i_lvl` after the optional synchronizer (see Configuration).
- **FSM states:** INIT, WAIT, REPORT.
- **INIT** (entered on reset):
  - On each tick: `o_lvl_q[o_sel]` ← `s[o_sel]`, then `o_sel` increments.
  - When a tick occurs with `o_sel` == N_CH-1, `o_sel` wraps to 0 and the FSM moves to WAIT.
  - No events are produced during INIT.
- **WAIT:** on a tick, compare `s[o_sel]` with `o_lvl_q[o_sel]`.
  - Equal: `o_sel` advances, wrapping N_CH-1 → 0. Stay in WAIT.
  - Different: `o_lvl_q[o_sel]` ← `s[o_sel]`; `o_edge_ch` ← `o_sel`; `o_edge_rise` ← `s[o_sel]`. Go to REPORT. `o_sel` holds.
- **REPORT:** `o_edge_vld` = 1.
  - On `o_edge_vld && i_edge_rdy`: the transfer completes; `o_sel` advances with wrap; go to WAIT.
  - A tick while in REPORT is lost: it sets `o_overrun` = 1. Sticky; only reset clears it.
- **Level changes between slots:** a channel that changes and returns before its slot produces no event (intended glitch rejection).
- **Multiple changed channels:** reported one per slot, in scan order starting from the current `o_sel`.

## Timing
- **Reset values (asynchronous, all outputs):** `o_slot_tick` 0, `o_sel` 0, `o_edge_vld` 0, `o_edge_ch` 0, `o_edge_rise` 0, `o_lvl_q` 0, `o_overrun` 0. The prescaler count is 0 and the synchronizer flops are 0.
- **Reset mid-operation:** a pending event is discarded and the INIT pass repeats.
- **INIT duration:** exactly N_CH ticks. The first tick falls at cycle TICK_DIV-1 after reset release.
- **Event launch:** tick in WAIT at cycle T → `o_edge_vld` and payload registered, valid from T+1.
- **Payload stability:** `o_edge_ch` and `o_edge_rise` stay stable while `o_edge_vld` = 1.
- **Handshake:** valid must not be dropped before the handshake. If `i_edge_rdy` = 1 at T+1, `o_edge_vld` = 0 at T+2 and `o_sel` is advanced at T+2.
- **`i_edge_rdy`:** may be asserted before valid and has no effect outside REPORT.
- **Worst-case edge-to-event latency:** sync delay + N_CH·TICK_DIV + 1 cycles, with the sink always ready.
- **Overrun:** impossible with a ready sink, since TICK_DIV ≥ 2.

## Configuration
- **`EDGE_SCAN_SYNC_EN` defined:** two-flop synchronizer on each `i_lvl` bit; `s` lags `i_lvl` by 2 cycles.
- **`EDGE_SCAN_SYNC_EN` undefined:** `s` = `i_lvl` directly. Use only for already-synchronous sources. Latency is 2 cycles shorter.

## Test plan
All scenarios use N_CH=4, TICK_DIV=4, sync enabled.
- **INIT capture:** reset with `i_lvl`=4'b1010 held, `i_edge_rdy`=1 → after 4 ticks (cycle 15), `o_lvl_q`=4'b1010; `o_edge_vld` never asserts; `o_sel`=0.
- **Rise/fall events, ready sink:** after INIT, set `i_lvl[2]` 0→1 → exactly one event with `o_edge_ch`=2, `o_edge_rise`=1, valid for 1 cycle, within 2+16+1 cycles. Then 1→0 gives `o_edge_rise`=0.
- **Backpressure:** hold `i_edge_rdy`=0 for 12 cycles during an event on ch1 → `o_edge_vld` held, payload constant, `o_sel`=1 throughout, `o_overrun`=1 after the first tick inside REPORT. Raising `i_edge_rdy` completes the transfer and scanning resumes at ch2.
- **Simultaneous changes:** flip ch0 and ch3 in the same cycle while `o_sel`=1 → events arrive in order ch3 then ch0, each exactly once; final `o_lvl_q` matches `i_lvl`.
- **Glitch rejection:** pulse `i_lvl[1]` high for 3 cycles right after ch1's slot → no event; `o_lvl_q[1]` unchanged.
- **Reset in REPORT:** assert `i_rst_n`=0 while `o_edge_vld`=1 → all outputs 0 immediately, without waiting for a clock edge. After release, a full INIT pass runs and no stale event appears.
